// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - four-digit BCD operand entry with debounced Enter key
module bcd_operand_entry #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] DigitIn,
    input  logic       Enter,
    input  logic       Clear,
    output logic [3:0] A1,
    output logic [3:0] A0,
    output logic [3:0] B1,
    output logic [3:0] B0,
    output logic       Valid,
    output logic       Err,
    output logic [2:0] Stage
);

    // Counter only has to reach DEBOUNCE_CNT-1; one extra value of headroom keeps CW >= 1.
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [2:0] {
        GET_A1 = 3'd0,
        GET_A0 = 3'd1,
        GET_B1 = 3'd2,
        GET_B0 = 3'd3,
        READY  = 3'd4
    } state_t;

    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic          deb_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press;
    logic          digit_ok;

    state_t        state_q, state_d;
    logic [3:0]    a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    // Two-flop synchronizer for the raw push-button level.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= Enter;
            s2_q <= s1_q;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CNT cycles before deb follows it.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                deb_d = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounce state and the delayed copy used for rising-edge detection.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            deb_q     <= 1'b0;
            cnt_q     <= '0;
            deb_dly_q <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            deb_dly_q <= deb_q;
        end
    end

    assign press    = deb_q & ~deb_dly_q;
    assign digit_ok = (DigitIn <= 4'd9);

    // Next-state logic: Clear first, then a press either captures or flags an error.
    always_comb begin
        state_d = state_q;
        a1_d    = a1_q;
        a0_d    = a0_q;
        b1_d    = b1_q;
        b0_d    = b0_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (Clear) begin
            state_d = GET_A1;
            a1_d    = 4'd0;
            a0_d    = 4'd0;
            b1_d    = 4'd0;
            b0_d    = 4'd0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (press) begin
            if (!digit_ok) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
                case (state_q)
                    GET_A1: begin
                        a1_d    = DigitIn;
                        state_d = GET_A0;
                    end
                    GET_A0: begin
                        a0_d    = DigitIn;
                        state_d = GET_B1;
                    end
                    GET_B1: begin
                        b1_d    = DigitIn;
                        state_d = GET_B0;
                    end
                    GET_B0: begin
                        b0_d    = DigitIn;
                        valid_d = 1'b1;
                        state_d = READY;
                    end
                    READY: begin
                        a1_d    = DigitIn;
                        valid_d = 1'b0;
                        state_d = GET_A0;
                    end
                    default: state_d = GET_A1;
                endcase
            end
        end else if (state_q > READY) begin
            state_d = GET_A1;
        end
    end

    // Operand registers and FSM state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= GET_A1;
            a1_q    <= 4'd0;
            a0_q    <= 4'd0;
            b1_q    <= 4'd0;
            b0_q    <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a0_q    <= a0_d;
            b1_q    <= b1_d;
            b0_q    <= b0_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign A1    = a1_q;
    assign A0    = a0_q;
    assign B1    = b1_q;
    assign B0    = b0_q;
    assign Valid = valid_q;
    assign Err   = err_q;
    assign Stage = state_q;

endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
- Upstream operand-entry stage for the two-digit BCD adder.
- Collects four BCD digits (A1, A0, B1, B0) one at a time from a 4-bit switch bank. Each digit is committed by a debounced Enter push-button press.
- Presents the digits as registered outputs that drive the adder's A1/A0/B1/B0 inputs directly. Valid flags a complete operand pair.
- Rejects non-BCD digits (10-15) and flags the error.

Parameters:
DEBOUNCE_CNT, 4, consecutive synchronized cycles a new Enter level must persist before it is accepted; legal range 1..2^20 (board build uses 500000)

Ports:
Clock    input   1  system clock; all state changes on its rising edge
Reset_n  input   1  asynchronous, active-low reset
DigitIn  input   4  digit from switches, sampled directly (static while operator presses)
Enter    input   1  raw push-button level, active-high, asynchronous to Clock
Clear    input   1  synchronous clear, active-high, already synchronous to Clock
A1       output  4  tens digit of operand A, registered
A0       output  4  units digit of operand A, registered
B1       output  4  tens digit of operand B, registered
B0       output  4  units digit of operand B, registered
Valid    output  1  all four digits captured since last clear/new entry
Err      output  1  last press offered a non-BCD digit
Stage    output  3  current state encoding (LED indication)

Behaviour:
Clocking and reset:
- One clock. Reset is asynchronous and active-low.
- Reset_n=0 forces: A1=A0=B1=B0=0, Valid=0, Err=0, Stage=0 (GET_A1).
- Reset_n=0 also clears the synchronizer, debounce counter, debounced level and edge register to 0.
- Reset mid-entry discards all partial digits.

Enter conditioning:
- 2-flop synchronizer: Enter -> s1 -> s2.
- Debouncer: counter increments each cycle s2 != deb; clears to 0 on any cycle s2 == deb.
- When the counter is at DEBOUNCE_CNT-1 and s2 != deb, deb toggles and the counter clears.
- Glitches shorter than DEBOUNCE_CNT synchronized cycles never reach deb.
- Press pulse = deb & ~deb_q, where deb_q is deb registered. One pulse per press; release generates nothing.
- Latency: raw Enter rise settled before edge N means the capture occurs on edge N+2+DEBOUNCE_CNT. With default 4, capture is on the 7th edge counted from N.

FSM (Stage encoding): GET_A1=0, GET_A0=1, GET_B1=2, GET_B0=3, READY=4. Codes 5-7 recover to GET_A1.
- GET_x with press and DigitIn<=9:
  - Capture DigitIn into the matching output register.
  - Err<=0.
  - Advance: A1->A0->B1->B0->READY.
- GET_x with press and DigitIn>9:
  - No capture; stay in state.
  - Err<=1. Err holds until the next valid press, Clear or reset.
- READY:
  - Valid=1 (registered; rises on the same edge that captures B0).
  - Press with valid digit: A1<=DigitIn, Valid<=0, go to GET_A0. A0/B1/B0 keep their old values until overwritten.
  - Press with invalid digit: remain in READY, Valid stays 1, Err<=1.
- Clear=1 (priority over press, any state): digits to 0, Valid<=0, Err<=0, go to GET_A1 on the next edge.
- Clear coincident with a press: Clear wins and the press is consumed (not replayed).
- Outputs change only on the capture edge; digits are stable between captures. This guarantees the adder sees a glitch-free operand.
- All output values are always in 0..9; a non-BCD value never reaches the outputs.

Test Plan:
- Reset: Reset_n=0 mid-count -> all digit outputs 0, Valid=0, Err=0, Stage=0 asynchronously, before the next Clock edge.
- Full entry, DEBOUNCE_CNT=4:
  - Press with DigitIn=9, 8, 7, 6 -> A1=9, A0=8, B1=7, B0=6.
  - Stage steps 0,1,2,3,4.
  - Valid=1 on the edge capturing B0.
  - Each capture lands exactly 7 edges after the raw rise.
- Invalid digit: in GET_A0, press with DigitIn=12 -> A0 unchanged, Stage=1, Err=1. Then press with 5 -> A0=5, Err=0, Stage=2.
- Bounce rejection: Enter pulses high for 3 cycles, low for 2, high for 3 -> no capture, Stage unchanged. A steady 6-cycle high then captures exactly once.
- Re-entry from READY: with Valid=1, press with DigitIn=3 -> A1=3, Valid=0, Stage=1, and A0/B1/B0 keep their previous values.
- Clear vs press: Clear asserted in the same cycle as a press pulse, state GET_B1 -> Stage=0, all digits 0, Err=0, no capture.
